// File: rtl/ballot_collector_pkg.sv
// Shared types, sizes and helpers for the ballot collector.
package ballot_collector_pkg;

    localparam int NUM_VOTERS = 5;
    localparam int CHOICE_W   = 3;
    localparam int ID_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // True when exactly one bit of the choice is set.
    function automatic logic is_onehot(input logic [CHOICE_W-1:0] v);
        return (v != '0) && ((v & (v - CHOICE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// Clearable round timer; tc_o flags the last permitted collection cycle.
module ballot_timer #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ballot_collector.sv
// Collects one ballot per voter per round and hands the latched set downstream.
//   state   | meaning
//   IDLE    | waiting for start; ballots from the last round held
//   COLLECT | accepting ballots until all five voted or the timer expires
//   DONE    | one cycle announcing the ballots are final
module ballot_collector
    import ballot_collector_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                vote_valid_i,
    input  logic [ID_W-1:0]     voter_id_i,
    input  logic [CHOICE_W-1:0] vote_i,
    output logic                accept_o,
    output logic                reject_o,
    output logic [CHOICE_W-1:0] in_1_o,
    output logic [CHOICE_W-1:0] in_2_o,
    output logic [CHOICE_W-1:0] in_3_o,
    output logic [CHOICE_W-1:0] in_4_o,
    output logic [CHOICE_W-1:0] in_5_o,
    output logic [NUM_VOTERS-1:0] voted_o,
    output logic                busy_o,
    output logic                ballots_valid_o
);

    state_e state_q;
    state_e state_d;

    logic [NUM_VOTERS-1:0][CHOICE_W-1:0] in_q;
    logic [NUM_VOTERS-1:0][CHOICE_W-1:0] in_d;
    logic [NUM_VOTERS-1:0]               voted_q;
    logic [NUM_VOTERS-1:0]               voted_d;

    logic accept_q;
    logic accept_d;
    logic reject_q;
    logic reject_d;
    logic busy_q;
    logic valid_q;

    logic timer_clr;
    logic timer_en;
    logic timer_tc;
    logic hit;

    ballot_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .tc_o    (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        voted_d   = voted_q;
        accept_d  = 1'b0;
        reject_d  = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        hit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    in_d      = '0;
                    voted_d   = '0;
                    timer_clr = 1'b1;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                timer_en = 1'b1;
                // Out-of-range ids never match a slot and fall through to reject.
                for (int k = 0; k < NUM_VOTERS; k++) begin
                    if (vote_valid_i && (voter_id_i == ID_W'(k + 1)) &&
                        is_onehot(vote_i) && !voted_q[k]) begin
                        in_d[k]    = vote_i;
                        voted_d[k] = 1'b1;
                        hit        = 1'b1;
                    end
                end
                accept_d = vote_valid_i && hit;
                reject_d = vote_valid_i && !hit;
                if ((voted_d == '1) || timer_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            in_q     <= '0;
            voted_q  <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_q     <= in_d;
            voted_q  <= voted_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
            busy_q   <= (state_d == COLLECT);
            valid_q  <= (state_d == DONE);
        end
    end

    assign accept_o        = accept_q;
    assign reject_o        = reject_q;
    assign in_1_o          = in_q[0];
    assign in_2_o          = in_q[1];
    assign in_3_o          = in_q[2];
    assign in_4_o          = in_q[3];
    assign in_5_o          = in_q[4];
    assign voted_o         = voted_q;
    assign busy_o          = busy_q;
    assign ballots_valid_o = valid_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed and random voting rounds checked against a per-cycle ballot model.
module tb_ballot_collector;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vote_valid = 1'b0;
    logic [2:0] voter_id = 3'd0;
    logic [2:0] vote = 3'd0;
    logic       accept, reject, busy, ballots_valid;
    logic [2:0] in1, in2, in3, in4, in5;
    logic [4:0] voted;

    int total = 0;
    int bad = 0;

    logic       cv [16];
    logic [2:0] cid [16];
    logic [2:0] cvt [16];
    logic       cst [16];
    int         ncyc;

    logic [2:0] exp_in [5];
    logic [4:0] exp_voted;

    ballot_collector #(.TIMEOUT(TO), .TW(4)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .vote_valid_i    (vote_valid),
        .voter_id_i      (voter_id),
        .vote_i          (vote),
        .accept_o        (accept),
        .reject_o        (reject),
        .in_1_o          (in1),
        .in_2_o          (in2),
        .in_3_o          (in3),
        .in_4_o          (in4),
        .in_5_o          (in5),
        .voted_o         (voted),
        .busy_o          (busy),
        .ballots_valid_o (ballots_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] dut_ins();
        return {in5, in4, in3, in2, in1};
    endfunction

    function automatic logic [14:0] exp_ins();
        return {exp_in[4], exp_in[3], exp_in[2], exp_in[1], exp_in[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) begin
            cv[i] = 1'b0; cid[i] = 3'd0; cvt[i] = 3'd0; cst[i] = 1'b0;
        end
        ncyc = 0;
    endtask

    task automatic plan(input int c, input logic [2:0] id, input logic [2:0] v);
        cv[c] = 1'b1; cid[c] = id; cvt[c] = v;
        if (c + 1 > ncyc) ncyc = c + 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, {28'd0, accept, reject, busy, ballots_valid}, 32'd0);
        chk({tag, "_voted"}, {27'd0, voted}, 32'd0);
        chk({tag, "_ins"}, {17'd0, dut_ins()}, 32'd0);
    endtask

    // Opens a round, plays the plan, and follows the round back to IDLE.
    // abort_after > 0 returns mid-COLLECT after that many cycles.
    task automatic run_round(input int abort_after, input logic start_in_done);
        logic pa, pr, done_now;
        start = 1'b1; vote_valid = 1'b0;
        step();
        start = 1'b0;
        exp_voted = '0;
        for (int k = 0; k < 5; k++) exp_in[k] = 3'd0;
        chk("open_busy", {31'd0, busy}, 32'd1);
        chk("open_voted", {27'd0, voted}, 32'd0);
        chk("open_ins", {17'd0, dut_ins()}, 32'd0);
        chk("open_flags", {29'd0, accept, reject, ballots_valid}, 32'd0);
        for (int i = 1; i <= TO; i++) begin
            if (i - 1 < ncyc) begin
                vote_valid = cv[i-1]; voter_id = cid[i-1]; vote = cvt[i-1]; start = cst[i-1];
            end else begin
                vote_valid = 1'b0; start = 1'b0;
            end
            pa = 1'b0; pr = 1'b0;
            if (vote_valid) begin
                if (voter_id >= 3'd1 && voter_id <= 3'd5 && $countones(vote) == 1 &&
                    !exp_voted[voter_id - 3'd1]) begin
                    pa = 1'b1;
                    exp_voted[voter_id - 3'd1] = 1'b1;
                    exp_in[voter_id - 3'd1] = vote;
                end else begin
                    pr = 1'b1;
                end
            end
            done_now = (exp_voted == 5'h1f) || (i == TO);
            step();
            vote_valid = 1'b0; start = 1'b0;
            chk("accept", {31'd0, accept}, {31'd0, pa});
            chk("reject", {31'd0, reject}, {31'd0, pr});
            chk("voted", {27'd0, voted}, {27'd0, exp_voted});
            chk("ins", {17'd0, dut_ins()}, {17'd0, exp_ins()});
            chk("busy", {31'd0, busy}, {31'd0, !done_now});
            chk("ballots_valid", {31'd0, ballots_valid}, {31'd0, done_now});
            if (i == abort_after) return;
            if (done_now) break;
        end
        // DONE cycle: a stray ballot and optional start must both be ignored.
        vote_valid = 1'b1; voter_id = 3'd1; vote = 3'b001; start = start_in_done;
        step();
        vote_valid = 1'b0; start = 1'b0;
        chk("idle_flags", {28'd0, accept, reject, busy, ballots_valid}, 32'd0);
        chk("idle_voted", {27'd0, voted}, {27'd0, exp_voted});
        chk("idle_ins", {17'd0, dut_ins()}, {17'd0, exp_ins()});
        vote_valid = 1'b1; voter_id = 3'd2; vote = 3'b010;
        step();
        vote_valid = 1'b0;
        chk("idle_vote_ignored", {28'd0, accept, reject, busy, ballots_valid}, 32'd0);
        chk("idle_hold_voted", {27'd0, voted}, {27'd0, exp_voted});
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // all five voters on consecutive cycles
        clear_plan();
        plan(0, 3'd1, 3'b001); plan(1, 3'd2, 3'b001); plan(2, 3'd3, 3'b010);
        plan(3, 3'd4, 3'b100); plan(4, 3'd5, 3'b001);
        run_round(0, 1'b0);
        chk("full_round_ins", {17'd0, dut_ins()}, {17'd0, 15'b001_100_010_001_001});
        chk("full_round_voted", {27'd0, voted}, 32'h1f);

        // duplicate voter
        clear_plan();
        plan(0, 3'd2, 3'b010); plan(1, 3'd2, 3'b100);
        run_round(0, 1'b0);
        chk("dup_in2", {29'd0, in2}, 32'b010);

        // malformed ballots
        clear_plan();
        plan(0, 3'd1, 3'b011); plan(1, 3'd1, 3'b000); plan(2, 3'd6, 3'b001);
        run_round(0, 1'b0);
        chk("bad_voted", {27'd0, voted}, 32'd0);

        // timeout with two voters
        clear_plan();
        plan(0, 3'd1, 3'b100); plan(2, 3'd3, 3'b001);
        run_round(0, 1'b0);
        chk("timeout_abstain", {20'd0, in5, in4, in2}, 32'd0);

        // last ballot lands on the timeout cycle; start while busy and in DONE
        clear_plan();
        plan(0, 3'd1, 3'b001); plan(1, 3'd2, 3'b010); plan(2, 3'd3, 3'b100);
        plan(3, 3'd4, 3'b001); plan(7, 3'd5, 3'b010);
        cst[2] = 1'b1; cst[5] = 1'b1;
        run_round(0, 1'b1);
        chk("late_voted", {27'd0, voted}, 32'h1f);

        // reset mid-round
        clear_plan();
        plan(0, 3'd1, 3'b001); plan(1, 3'd2, 3'b010); plan(2, 3'd3, 3'b100);
        run_round(3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        clear_plan();
        plan(0, 3'd5, 3'b100); plan(1, 3'd4, 3'b010); plan(2, 3'd3, 3'b001);
        plan(3, 3'd2, 3'b100); plan(4, 3'd1, 3'b010);
        run_round(0, 1'b0);

        // random rounds
        for (int r = 0; r < 8; r++) begin
            clear_plan();
            for (int c = 0; c < TO; c++) begin
                cv[c]  = ($urandom_range(0, 3) != 0);
                cid[c] = 3'($urandom_range(0, 7));
                cvt[c] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7))
                                                     : 3'(1 << $urandom_range(0, 2));
                cst[c] = ($urandom_range(0, 5) == 0);
            end
            ncyc = TO;
            run_round(0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
